logic_axi4_lite_register_bank: RTL
==================================

// Module: logic_axi4_lite_register_bank
// PURPOSE
//  AXI4-Lite slave terminating a master-side AXI4-Lite path (e.g. the queue output) into a bank of
//  REGISTERS word-wide, byte-strobed, read/write control registers. Register contents are exported
//  in parallel to fabric logic. Each write commit raises a one-cycle per-register strobe.
//  Handles the independent AW/W/B/AR/R channels, decodes addresses and generates OKAY/SLVERR responses.
// PARAMETERS
//  DATA_BYTES     4   bytes per data word (power of two, >=1)
//  ADDRESS_WIDTH  8   AXI address width; must satisfy 2**ADDRESS_WIDTH >= REGISTERS*DATA_BYTES
//  REGISTERS      16  number of registers (>=1); word index = addr >> $clog2(DATA_BYTES)
// PORTS
//  aclk             in   1                   clock, all logic on rising edge
//  areset_n         in   1                   asynchronous active-low reset
//  slave_awvalid    in   1                   write address valid
//  slave_awaddr     in   ADDRESS_WIDTH       write byte address
//  slave_awprot     in   access_t            protection (accepted, ignored)
//  slave_awready    out  1                   write address ready
//  slave_wvalid     in   1                   write data valid
//  slave_wdata      in   DATA_BYTES*8        write data
//  slave_wstrb      in   DATA_BYTES          byte write strobes
//  slave_wready     out  1                   write data ready
//  slave_bready     in   1                   write response ready
//  slave_bvalid     out  1                   write response valid
//  slave_bresp      out  response_t          OKAY or SLVERR
//  slave_arvalid    in   1                   read address valid
//  slave_araddr     in   ADDRESS_WIDTH       read byte address
//  slave_arprot     in   access_t            protection (accepted, ignored)
//  slave_arready    out  1                   read address ready
//  slave_rready     in   1                   read data ready
//  slave_rvalid     out  1                   read data valid
//  slave_rdata      out  DATA_BYTES*8        read data
//  slave_rresp      out  response_t          OKAY or SLVERR
//  registers        out  REGISTERS*DATA_BYTES*8  current contents, registered
//  register_written out  REGISTERS           1-cycle pulse per register on write commit
// BEHAVIOUR
//  Reset (async assert, sync release): all registers=0, all holds cleared, bvalid=rvalid=0,
//   bresp=rresp=OKAY, rdata=0, register_written=0; awready=wready=arready=0 while reset is asserted,
//   1 in the first cycle after release.
//  Write path: AW and W are captured independently into holding regs; awready=!aw_held, wready=!w_held.
//   Commit condition: aw_held & w_held & (!bvalid | bready). On the commit edge:
//   - addressed register updated byte-wise per wstrb;
//   - aw_held and w_held cleared;
//   - bvalid<=1; bresp is OKAY if in range, otherwise SLVERR;
//   - register_written[idx] pulses for exactly that cycle.
//   AW+W handshake at edge N -> commit at edge N+1 -> bvalid high from N+1 until B handshake.
//   Peak throughput is one write per 2 cycles. bvalid is held with stable bresp until bready.
//  Out-of-range write (idx>=REGISTERS): no register change, no strobe, bresp=SLVERR.
//  wstrb==0: no data change, strobe still pulses, OKAY.
//  Read path: arready=!rvalid | rready.
//   On AR handshake at edge N: rdata is sampled from current contents and rvalid is set (visible after N).
//   Out-of-range read: rdata=0, rresp=SLVERR.
//   rdata/rresp are stable while rvalid & !rready. Back-to-back reads at 1/cycle with rready held high.
//  Address LSBs below $clog2(DATA_BYTES) ignored (unaligned access maps to containing word).
//  Simultaneous read and write commit to the same register on one edge: read returns OLD value.
//  Read and write channels fully independent; no ordering between them.
//  Reset asserted mid-transaction: all pending AW/W/B/R state discarded immediately; no response issued.
// TESTING
//  W to reg 3 (addr 0x0C, 0xDEADBEEF, strb 0xF) -> bvalid 1 cycle after commit, OKAY, registers[3]=0xDEADBEEF, register_written[3] one pulse.
//  W precedes AW by 3 cycles -> wready drops after W capture, commit only after AW, single B.
//  strb 0x2, data 0x0000AB00 over 0xDEADBEEF -> reg=0xDEADABEF; read addr 0x0C returns 0xDEADABEF OKAY.
//  Write/read addr 0x40 (idx 16, out of range) -> bresp/rresp SLVERR, rdata 0, no register changes.
//  bready/rready low for 5 cycles -> B/R stable; second AW+W captured but not committed until B taken.
//  Same-edge write 0x1 and read of reg 0 (was 0x0) -> rdata 0x0, registers[0]=0x1; reset mid-write -> all outputs to reset values.

Source files
------------

// File: rtl/logic_axi4_lite_register_bank_if.sv
// logic_axi4_lite_register_bank_if: AXI4-Lite channel types and slave-side bus interface
package logic_axi4_lite_register_bank_pkg;
  typedef logic [2:0] access_t;
  typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} response_t;
endpackage

interface logic_axi4_lite_register_bank_if #(
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 8
);
  import logic_axi4_lite_register_bank_pkg::*;
  logic                       awvalid;
  logic [ADDRESS_WIDTH-1:0]   awaddr;
  access_t                    awprot;
  logic                       awready;
  logic                       wvalid;
  logic [DATA_BYTES*8-1:0]    wdata;
  logic [DATA_BYTES-1:0]      wstrb;
  logic                       wready;
  logic                       bready;
  logic                       bvalid;
  response_t                  bresp;
  logic                       arvalid;
  logic [ADDRESS_WIDTH-1:0]   araddr;
  access_t                    arprot;
  logic                       arready;
  logic                       rready;
  logic                       rvalid;
  logic [DATA_BYTES*8-1:0]    rdata;
  response_t                  rresp;
  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/logic_axi4_lite_register_bank.sv
// logic_axi4_lite_register_bank: AXI4-Lite slave exposing a bank of byte-strobed control registers
module logic_axi4_lite_register_bank
  import logic_axi4_lite_register_bank_pkg::*;
#(
  parameter int DATA_BYTES    = 4,
  parameter int ADDRESS_WIDTH = 8,
  parameter int REGISTERS     = 16
) (
  input  logic                               aclk,
  input  logic                               areset_n,
  logic_axi4_lite_register_bank_if.slave     slave,
  output logic [REGISTERS*DATA_BYTES*8-1:0]  registers,
  output logic [REGISTERS-1:0]               register_written
);
  localparam int W    = DATA_BYTES * 8;
  localparam int LSB  = $clog2(DATA_BYTES);
  localparam int IDXW = ADDRESS_WIDTH - LSB;
  logic            aw_held, w_held, commit, rd_hit;
  logic [IDXW-1:0] aw_idx;
  logic [W-1:0]    w_data, rd_word;
  logic [DATA_BYTES-1:0] w_strb;
  logic [REGISTERS-1:0]  wr_sel;
  logic [IDXW-1:0] ar_idx;
  assign slave.awready = areset_n & !aw_held;
  assign slave.wready  = areset_n & !w_held;
  assign slave.arready = areset_n & (!slave.rvalid | slave.rready);
  assign commit        = aw_held & w_held & (!slave.bvalid | slave.bready);
  assign ar_idx        = slave.araddr[ADDRESS_WIDTH-1:LSB];
  // Decode the held write index into a one-hot commit select; empty when out of range
  always_comb begin
    wr_sel = '0;
    for (int r = 0; r < REGISTERS; r++) wr_sel[r] = commit & (aw_idx == IDXW'(r));
  end
  // Select the read word for the presented address; rd_hit clear means out of range
  always_comb begin
    rd_word = '0;
    rd_hit  = 1'b0;
    for (int r = 0; r < REGISTERS; r++)
      if (ar_idx == IDXW'(r)) begin
        rd_word = registers[r*W +: W];
        rd_hit  = 1'b1;
      end
  end
  // Write path: independent AW/W capture, commit into the bank, B response and write strobes
  always_ff @(posedge aclk or negedge areset_n)
    if (!areset_n) begin
      aw_held          <= 1'b0;
      aw_idx           <= '0;
      w_held           <= 1'b0;
      w_data           <= '0;
      w_strb           <= '0;
      slave.bvalid     <= 1'b0;
      slave.bresp      <= OKAY;
      registers        <= '0;
      register_written <= '0;
    end else begin
      aw_held          <= commit ? 1'b0 : aw_held | slave.awvalid;
      w_held           <= commit ? 1'b0 : w_held | slave.wvalid;
      if (slave.awvalid & slave.awready) aw_idx <= slave.awaddr[ADDRESS_WIDTH-1:LSB];
      if (slave.wvalid & slave.wready) begin
        w_data <= slave.wdata;
        w_strb <= slave.wstrb;
      end
      slave.bvalid     <= commit | (slave.bvalid & !slave.bready);
      if (commit) slave.bresp <= |wr_sel ? OKAY : SLVERR;
      register_written <= wr_sel;
      for (int r = 0; r < REGISTERS; r++)
        for (int b = 0; b < DATA_BYTES; b++)
          if (wr_sel[r] && w_strb[b]) registers[r*W + b*8 +: 8] <= w_data[b*8 +: 8];
    end
  // Read path: sample the current contents on AR handshake and hold until R is taken
  always_ff @(posedge aclk or negedge areset_n)
    if (!areset_n) begin
      slave.rvalid <= 1'b0;
      slave.rdata  <= '0;
      slave.rresp  <= OKAY;
    end else if (slave.arvalid & slave.arready) begin
      slave.rvalid <= 1'b1;
      slave.rdata  <= rd_word;
      slave.rresp  <= rd_hit ? OKAY : SLVERR;
    end else if (slave.rready) begin
      slave.rvalid <= 1'b0;
    end
endmodule
